sigmoid_arbiter: RTL and testbench
==================================

# sigmoid_arbiter

Shares one combinational `Sigmoid_LUT` between `N_REQ` neuron accumulators in the mine-detection ANN layer. Each neuron presents a signed-magnitude sum (`suma` plus `predznak`) with a valid/ready handshake. The arbiter grants requesters round-robin, registers the LUT operands, captures `vjerojatnost` one cycle later, and returns it tagged with the requester index. It sits between the neuron MAC units and the next-layer input buffer.

## Interface
- `N_REQ`, default 4: number of requesting neurons, 2..16.
- `SUM_W`, default 22: width of the `suma` magnitude.
- `PROB_W`, default 16: width of `vjerojatnost`.
- `ID_W`, default `$clog2(N_REQ)`: width of the result tag.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N_REQ: per-neuron request.
- `req_suma` in N_REQ*SUM_W: packed magnitudes; slice i belongs to neuron i.
- `req_predznak` in N_REQ: sign per neuron; 1 = negative.
- `req_ready` out N_REQ: one-hot accept pulse.
- `lut_suma` out SUM_W: registered LUT operand.
- `lut_predznak` out 1: registered LUT sign.
- `lut_vjerojatnost` in PROB_W: LUT output, combinational from `lut_*`.
- `res_valid` out 1: result available.
- `res_id` out ID_W: index of the granted neuron.
- `res_vjerojatnost` out PROB_W: captured LUT output.
- `res_ready` in 1: downstream accepts the result.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE → LOOK when any `req_valid` is high.
  - LOOK → OUT unconditionally.
  - OUT → IDLE when `res_ready` is high; otherwise stay in OUT.
- IDLE with any request:
  - Pick the first set `req_valid` at or after `rr_ptr`, scanning upward and wrapping at N_REQ-1 → 0.
  - Pulse `req_ready[g]` for this cycle only.
  - Load `lut_suma`/`lut_predznak` from slice g and load `res_id` ← g.
  - Set `rr_ptr` ← (g+1) mod N_REQ.
- LOOK: on exit, `res_vjerojatnost` ← `lut_vjerojatnost`.
- OUT: `res_valid` = 1. `res_id` and `res_vjerojatnost` hold until `res_ready`.
- `req_ready` is low in LOOK and OUT, so no request is accepted while a lookup is outstanding.
- Requesters hold `req_valid` and their data until they see `req_ready`. A request dropped before grant is simply not served.
- `lut_suma`/`lut_predznak` keep their last value between grants; they are not cleared.
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `lut_suma` 0, `lut_predznak` 0, `res_valid` 0, `res_id` 0, `res_vjerojatnost` 0, `busy` 0.
- Reset mid-operation (LOOK or OUT): the pending result is discarded with no `res_valid` pulse. The requester has already been acknowledged and must re-issue.
- No arithmetic is performed. Widths pass through unchanged, and `suma` is not saturated or rescaled.

## Timing
- Grant in cycle t: `req_ready` high in t, LUT operands valid from t+1, `res_valid` high from t+2.
- If `res_ready` is high in the first OUT cycle (t+2), that is the transfer cycle, state is IDLE at t+3, and the next grant can occur at t+3.
- Peak throughput is one result per 3 cycles.
- All requesters continuously valid: grants go 0,1,2,3,0,... with no starvation. Worst-case wait for any requester is N_REQ grants.
- Backpressure: holding `res_ready` low stalls the FSM in OUT indefinitely with outputs stable.
- The LUT must settle within one clock period; LOOK is its only evaluation window.

## Structure
- Shared package `ann_pkg`: `SUM_W`, `PROB_W`, the FSM state encoding (IDLE, LOOK, OUT).
- Sub-module `rr_pick`:
  - Combinational: `req_valid` + `rr_ptr` → `any`, one-hot `grant`, binary `gidx`.
  - Reused later by the layer weight-memory arbiter.
- `Sigmoid_LUT` is instantiated beside this block at layer level, not inside it.

## Test plan
- Single request: neuron 2 with `suma`=22'h004C44, `predznak`=0 at cycle 0 → `req_ready`=4'b0100 in cycle 0; `res_valid` at cycle 2 with `res_id`=2 and `res_vjerojatnost` equal to the LUT model value.
- Same operand with `predznak`=1 → result equals the LUT model output for the negative input, differing from the positive case.
- All four neurons valid continuously, `res_ready`=1 → grants in order 0,1,2,3,0, spaced 3 cycles apart.
- Backpressure: `res_ready` low for 5 cycles after `res_valid` → `res_valid`, `res_id`, `res_vjerojatnost` stable for 5 cycles, no `req_ready`, `busy`=1.
- `rr_ptr`=3 with requests on neurons 1 and 3 → neuron 3 is granted first, then neuron 1; `rr_ptr` then becomes 2.
- `rst` asserted in LOOK → next cycle all outputs are at reset values, no `res_valid` pulse occurs, and a later request on neuron 0 is granted first.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared constants and types for the mine-detection ANN layer blocks.
// Holds the datapath widths and the sigmoid arbiter state encoding.
package ann_pkg;

    localparam int SUM_W  = 22;
    localparam int PROB_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOK = 2'd1,
        ST_OUT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set valid at or after ptr,
// scanning upward with wrap. Shared with the layer weight-memory arbiter.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx
);

    int idx;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        gidx  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            // ptr is always kept below N, so one subtraction covers the wrap
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one combinational sigmoid LUT between N_REQ
// neurons: grant, register operands, capture the LUT one cycle later, hold.
module sigmoid_arbiter
    import ann_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SUM_W_P = SUM_W,
    parameter int PROB_W_P = PROB_W,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*SUM_W_P-1:0]    req_suma,
    input  logic [N_REQ-1:0]            req_predznak,
    output logic [N_REQ-1:0]            req_ready,
    output logic [SUM_W_P-1:0]          lut_suma,
    output logic                        lut_predznak,
    input  logic [PROB_W_P-1:0]         lut_vjerojatnost,
    output logic                        res_valid,
    output logic [ID_W-1:0]             res_id,
    output logic [PROB_W_P-1:0]         res_vjerojatnost,
    input  logic                        res_ready,
    output logic                        busy
);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SUM_W_P-1:0]    lut_suma_q, lut_suma_d;
    logic                  lut_predznak_q, lut_predznak_d;
    logic [ID_W-1:0]       res_id_q, res_id_d;
    logic [PROB_W_P-1:0]   res_prob_q, res_prob_d;

    logic                  any;
    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       gidx;
    logic                  accept;

    rr_pick #(
        .N  (N_REQ),
        .PW (ID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .any   (any),
        .grant (grant),
        .gidx  (gidx)
    );

    assign accept = (state_q == ST_IDLE) && any;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any)       state_d = ST_LOOK;
            ST_LOOK:                state_d = ST_OUT;
            ST_OUT:  if (res_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs; the accept pulse is suppressed while reset is held
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && !rst) req_ready = grant;
        res_valid = (state_q == ST_OUT);
        busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        lut_suma_d     = lut_suma_q;
        lut_predznak_d = lut_predznak_q;
        res_id_d       = res_id_q;
        res_prob_d     = res_prob_q;
        if (accept) begin
            lut_suma_d     = req_suma[int'(gidx)*SUM_W_P +: SUM_W_P];
            lut_predznak_d = req_predznak[gidx];
            res_id_d       = gidx;
            rr_ptr_d       = (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + ID_W'(1);
        end
        if (state_q == ST_LOOK) res_prob_d = lut_vjerojatnost;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            lut_suma_q     <= '0;
            lut_predznak_q <= 1'b0;
            res_id_q       <= '0;
            res_prob_q     <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            lut_suma_q     <= lut_suma_d;
            lut_predznak_q <= lut_predznak_d;
            res_id_q       <= res_id_d;
            res_prob_q     <= res_prob_d;
        end
    end

    assign lut_suma         = lut_suma_q;
    assign lut_predznak     = lut_predznak_q;
    assign res_id           = res_id_q;
    assign res_vjerojatnost = res_prob_q;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter with a behavioural LUT and a result
// scoreboard filled at stimulus time and drained on each result transfer.
module tb_sigmoid_arbiter;

    localparam int N = 4;
    localparam int SW = 22;
    localparam int PW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*SW-1:0] req_suma;
    logic [N-1:0]    req_predznak;
    logic [N-1:0]    req_ready;
    logic [SW-1:0]   lut_suma;
    logic            lut_predznak;
    logic [PW-1:0]   lut_vjerojatnost;
    logic            res_valid;
    logic [1:0]      res_id;
    logic [PW-1:0]   res_vjerojatnost;
    logic            res_ready;
    logic            busy;

    typedef struct {
        logic [1:0]    id;
        logic [PW-1:0] prob;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    sigmoid_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_suma         (req_suma),
        .req_predznak     (req_predznak),
        .req_ready        (req_ready),
        .lut_suma         (lut_suma),
        .lut_predznak     (lut_predznak),
        .lut_vjerojatnost (lut_vjerojatnost),
        .res_valid        (res_valid),
        .res_id           (res_id),
        .res_vjerojatnost (res_vjerojatnost),
        .res_ready        (res_ready),
        .busy             (busy)
    );

    // Behavioural sigmoid: midpoint 0x8000, saturating offset, sign-symmetric
    function automatic logic [PW-1:0] lut_f(input logic [SW-1:0] s, input logic p);
        logic [PW-1:0] m;
        m = (s[SW-1:15] != '0) ? 16'h7FFF : {1'b0, s[14:0]};
        return p ? (16'h8000 - m) : (16'h8000 + m);
    endfunction

    assign lut_vjerojatnost = lut_f(lut_suma, lut_predznak);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard drain on every result transfer
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'(res_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_vjerojatnost", 32'(res_vjerojatnost), 32'(e.prob));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Single request from an idle arbiter, result taken on first OUT cycle
    task automatic single(input int id, input logic [SW-1:0] s, input logic p);
        req_suma[id*SW +: SW] = s;
        req_predznak[id]      = p;
        req_valid             = N'(1) << id;
        q.push_back('{id: 2'(id), prob: lut_f(s, p)});
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'(N'(1) << id));
        check("single_busy_idle", 32'(busy), 32'(0));
        step();
        req_valid = '0;
        @(negedge clk);
        check("look_busy", 32'(busy), 32'(1));
        check("look_lut_suma", 32'(lut_suma), 32'(s));
        check("look_lut_predznak", 32'(lut_predznak), 32'(p));
        check("look_no_valid", 32'(res_valid), 32'(0));
        step();
        @(negedge clk);
        check("out_valid", 32'(res_valid), 32'(1));
        step();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_suma     = '0;
        req_predznak = '0;
        res_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_res_id", 32'(res_id), 32'(0));
        check("rst_res_vjer", 32'(res_vjerojatnost), 32'(0));
        check("rst_lut_suma", 32'(lut_suma), 32'(0));
        check("rst_lut_predznak", 32'(lut_predznak), 32'(0));
        step();
        rst = 1'b0;

        // Neuron 2, positive then negative operand
        single(2, 22'h004C44, 1'b0);
        single(2, 22'h004C44, 1'b1);

        // Pointer now 3: neurons 1 and 3 request, 3 wins, then 1
        req_suma[1*SW +: SW] = 22'h000123; req_predznak[1] = 1'b1;
        req_suma[3*SW +: SW] = 22'h3F0000; req_predznak[3] = 1'b0;
        req_valid = 4'b1010;
        q.push_back('{id: 2'd3, prob: lut_f(22'h3F0000, 1'b0)});
        q.push_back('{id: 2'd1, prob: lut_f(22'h000123, 1'b1)});
        @(negedge clk);
        check("rr_first_grant", 32'(req_ready), 32'(4'b1000));
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        check("rr_look_no_ready", 32'(req_ready), 32'(0));
        step();
        @(negedge clk);
        check("rr_out_no_ready", 32'(req_ready), 32'(0));
        step();
        @(negedge clk);
        check("rr_second_grant", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid = '0;
        repeat (2) step();

        // Pointer should be 2: with 0,1,2 requesting only 2 qualifies first
        req_suma[0*SW +: SW] = 22'h000010;
        req_suma[2*SW +: SW] = 22'h000777; req_predznak[2] = 1'b0;
        req_valid = 4'b0111;
        q.push_back('{id: 2'd2, prob: lut_f(22'h000777, 1'b0)});
        @(negedge clk);
        check("rr_ptr_is_2", 32'(req_ready), 32'(4'b0100));
        step();
        req_valid = '0;
        repeat (3) step();

        // Backpressure: pointer 3, neuron 0 granted, neuron 1 waits behind it
        res_ready = 1'b0;
        req_suma[0*SW +: SW] = 22'h002A00; req_predznak[0] = 1'b1;
        req_valid = 4'b0001;
        q.push_back('{id: 2'd0, prob: lut_f(22'h002A00, 1'b1)});
        q.push_back('{id: 2'd1, prob: lut_f(22'h000123, 1'b1)});
        @(negedge clk);
        check("bp_grant", 32'(req_ready), 32'(4'b0001));
        step();
        req_valid = 4'b0010;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 32'(1));
            check("bp_res_id", 32'(res_id), 32'(0));
            check("bp_res_vjer", 32'(res_vjerojatnost), 32'(lut_f(22'h002A00, 1'b1)));
            check("bp_no_ready", 32'(req_ready), 32'(0));
            check("bp_busy", 32'(busy), 32'(1));
            step();
        end
        res_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid = '0;
        repeat (3) step();

        // Reset during LOOK discards the pending result
        req_valid = 4'b0010;
        @(negedge clk);
        check("rl_grant", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rl_res_valid", 32'(res_valid), 32'(0));
        check("rl_busy", 32'(busy), 32'(0));
        check("rl_req_ready", 32'(req_ready), 32'(0));
        check("rl_res_id", 32'(res_id), 32'(0));
        check("rl_res_vjer", 32'(res_vjerojatnost), 32'(0));
        check("rl_lut_suma", 32'(lut_suma), 32'(0));
        check("rl_lut_predznak", 32'(lut_predznak), 32'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rl_no_result", 32'(res_valid), 32'(0));
            step();
        end

        // All four continuously valid: 0,1,2,3,0 every third cycle
        for (int i = 0; i < N; i++) begin
            req_suma[i*SW +: SW] = SW'(22'h001000 * (i + 1) + i);
            req_predznak[i]      = 1'(i);
        end
        for (int g = 0; g < 5; g++) begin
            logic [SW-1:0] s;
            s = req_suma[(g % N)*SW +: SW];
            q.push_back('{id: 2'(g % N), prob: lut_f(s, req_predznak[g % N])});
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check("all_ready", 32'(req_ready), (k % 3 == 0) ? 32'(N'(1) << ((k / 3) % N)) : 32'(0));
            step();
        end
        req_valid = '0;

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check("scoreboard_empty", 32'(q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
